packet_router_stats_poller: RTL and testbench
=============================================

# packet_router_stats_poller

AXI-Lite read initiator that sweeps the packet router statistics register bank (output-0 count at 0x0, output-1 count at 0x4, dropped count at 0x8). It can be triggered once or run periodically. After each sweep it publishes the three counters as one coherent snapshot. It sits between the router's AXI-Lite statistics slave and local monitoring logic (rate meters, debug capture) that must not own an AXI master itself.

## Interface
Parameters:
- BASE_ADDR, 32'h0, byte address of the register bank; reads go to BASE_ADDR+0, +4, +8.
- POLL_INTERVAL, 1000, idle cycles between the end of one sweep and the start of the next when `enable`=1; legal range 1..2^24-1.
- TIMEOUT_CYCLES, 256, wait cycles in one AR or R phase before `err_timeout` is set; legal range 1..2^16-1.

Ports:
- clk  in  1  system clock; single clock domain.
- resetn  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request for one sweep; ignored while `busy`=1.
- enable  in  1  periodic polling on/off.
- clear_err  in  1  clears both sticky error flags.
- m_axil_araddr  out  32  read address.
- m_axil_arvalid  out  1  read address valid.
- m_axil_arready  in  1  read address ready.
- m_axil_rdata  in  32  read data.
- m_axil_rresp  in  2  read response.
- m_axil_rvalid  in  1  read data valid.
- m_axil_rready  out  1  read data ready.
- snap_out0, snap_out1, snap_dropped  out  32 each  last committed snapshot.
- delta_out0, delta_out1, delta_dropped  out  32 each  difference since the previous snapshot; see Configuration.
- snap_valid  out  1  one-cycle pulse when a snapshot commits.
- busy  out  1  high while a sweep is in progress.
- err_slverr  out  1  sticky flag; a read returned a non-OKAY response.
- err_timeout  out  1  sticky flag; an AR or R wait exceeded TIMEOUT_CYCLES.

## Operation
- FSM states: IDLE, AR, R, COMMIT, WAIT.
- IDLE goes to AR on `start`=1, or on `enable`=1 when first entered from reset. The read index is set to 0.
- AR: `arvalid`=1 and `araddr`=BASE_ADDR+4×index. `araddr` is held stable until handshake (arvalid&arready), then the FSM goes to R.
- R: `rready`=1. On rvalid&rready, `rdata` is captured into staging[index]. If `rresp`≠2'b00, a sweep-error bit is set. If index<2, index increments and the FSM goes to AR; otherwise it goes to COMMIT.
- COMMIT, one cycle:
  - If there is no sweep error, the staging registers copy to the snap_* outputs, `snap_valid` pulses, and the deltas update.
  - If there is a sweep error, the snap_* outputs and deltas keep their old values, `snap_valid` stays 0, and `err_slverr` is set.
  - The sweep-error bit is then cleared. The FSM goes to WAIT if `enable`=1, else to IDLE.
- WAIT: counts POLL_INTERVAL cycles, then goes to AR. If `enable` drops, the FSM goes to IDLE immediately.
- Timeout: a wait counter runs in AR and R and resets on each handshake. When it reaches TIMEOUT_CYCLES, `err_timeout` is set. The FSM keeps waiting: `arvalid` is never withdrawn before handshake, per AXI rules.
- `clear_err` clears both sticky flags. If a set event occurs in the same cycle as `clear_err`, set wins.
- `busy` is 1 in AR, R and COMMIT.
- `start` while `busy`=1 is dropped and not queued. `start` in WAIT begins the sweep immediately.

## Timing
- Reset values: `arvalid`=0, `rready`=0, `araddr`=BASE_ADDR; all snap_* and delta_* outputs are 0; `snap_valid`, `busy`, `err_slverr` and `err_timeout` are all 0; the FSM is in IDLE.
- All outputs are registered.
- `start` at cycle 0 gives `arvalid`=1 at cycle 1.
- With zero-wait-state slaves (arready=1, rvalid the cycle after the AR handshake), the three reads take 6 cycles. COMMIT is at cycle 7 and `snap_valid` is high at cycle 7.
- Reset asserted mid-sweep aborts immediately: outputs return to reset values and staged data is discarded.

## Configuration
- PACKET_ROUTER_POLL_DELTA_EN defined:
  - Each delta_* equals new snapshot minus previous committed snapshot, computed modulo 2^32 so counter wrap gives the correct small delta.
  - The previous snapshot after reset is 0, so the first delta equals the first snapshot.
- PACKET_ROUTER_POLL_DELTA_EN undefined: no subtractors are built and the delta_* ports are driven to constant 0.

## Test plan
- Zero-wait slave returning 10, 20, 3 at 0x0/0x4/0x8; pulse `start` -> araddr sequence 0x0, 0x4, 0x8; snap=10/20/3; `snap_valid` pulses at cycle 7; `busy` low at cycle 8.
- Slave holds arready=0 for 300 cycles, TIMEOUT_CYCLES=256 -> `err_timeout`=1 at wait cycle 256; `arvalid` and `araddr` stay stable; sweep completes normally afterwards.
- Second read returns rresp=2'b10 -> `err_slverr`=1; no `snap_valid`; snap_* unchanged; `clear_err` then clears the flag.
- `enable`=1, POLL_INTERVAL=5 -> consecutive sweeps start exactly 5 cycles after each COMMIT. Deasserting `enable` in WAIT -> IDLE, no further `arvalid`.
- Delta macro on; snapshots 0xFFFF_FFF0 then 0x0000_0010 on output 0 -> delta_out0=0x20. Macro off -> delta_out0=0.
- `resetn` low while in R -> `rready`=0, snap_* cleared, FSM in IDLE; a later `start` performs a clean sweep.

Source files
------------

// File: rtl/packet_router_stats_poller.sv
// rtl/packet_router_stats_poller.sv - AXI-Lite read initiator that sweeps router statistics into coherent snapshots
//
// Purpose:
//   Reads the output-0 (BASE+0x0), output-1 (BASE+0x4) and dropped (BASE+0x8)
//   counters over AXI-Lite, one sweep per start pulse or periodically while
//   enable is high, then publishes all three as one snapshot.
//   Optional feature macro: PACKET_ROUTER_POLL_DELTA_EN (builds the delta_* subtractors).
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   start, enable, clear_err    sweep request, periodic polling, sticky error clear
//   m_axil_ar*, m_axil_r*       AXI-Lite read address / read data channels (master side)
//   snap_out0/1/dropped         last committed snapshot
//   delta_out0/1/dropped        change since the previous snapshot (0 when delta feature is off)
//   snap_valid                  one-cycle pulse in the cycle a snapshot commits
//   busy                        sweep in progress (AR, R, COMMIT)
//   err_slverr, err_timeout     sticky error flags

module packet_router_stats_poller #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned POLL_INTERVAL  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        enable,
  input  logic        clear_err,
  output logic [31:0] m_axil_araddr,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready,
  output logic [31:0] snap_out0,
  output logic [31:0] snap_out1,
  output logic [31:0] snap_dropped,
  output logic [31:0] delta_out0,
  output logic [31:0] delta_out1,
  output logic [31:0] delta_dropped,
  output logic        snap_valid,
  output logic        busy,
  output logic        err_slverr,
  output logic        err_timeout
);

  localparam logic [23:0] POLL_LAST = 24'(POLL_INTERVAL - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TMO_MAX   = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR     = 3'd1,
    S_R      = 3'd2,
    S_COMMIT = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        boot_q;
  logic        sweep_err_q, sweep_err_d;
  logic [31:0] stage0_q, stage1_q;

  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        busy_q, busy_d;
  logic [31:0] snap0_q, snap1_q, snap2_q;
  logic        snap_valid_q;
  logic        err_slverr_q, err_timeout_q;

  logic ar_hs, r_hs, stall, tmo_hit;
  logic commit_now, commit_err, commit_ok;

  assign ar_hs = arvalid_q & m_axil_arready;
  assign r_hs  = rready_q & m_axil_rvalid;

  // A phase is stalled when we are presenting a valid/ready and the slave has not completed it.
  assign stall   = ((state_q == S_AR) & ~ar_hs) | ((state_q == S_R) & ~r_hs);
  // The counter saturates at TIMEOUT_CYCLES so the flag is raised once per stalled phase,
  // which lets a clear_err during a long stall actually stick.
  assign tmo_hit = stall & (tmo_cnt_q == TMO_LAST);

  // The third read's data and response are folded straight into the commit,
  // so the snapshot and snap_valid are both visible during the COMMIT cycle.
  assign commit_now = r_hs & (idx_q == 2'd2);
  assign commit_err = sweep_err_q | (m_axil_rresp != 2'b00);
  assign commit_ok  = commit_now & ~commit_err;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start || (enable && boot_q)) state_d = S_AR;
      S_AR:     if (ar_hs) state_d = S_R;
      S_R:      if (r_hs) state_d = (idx_q == 2'd2) ? S_COMMIT : S_AR;
      S_COMMIT: state_d = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (start)                        state_d = S_AR;
        else if (!enable)                 state_d = S_IDLE;
        else if (poll_cnt_q == POLL_LAST) state_d = S_AR;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state and registered-output next-state logic
  always_comb begin
    idx_d = idx_q;
    if (state_q == S_IDLE || state_q == S_WAIT) begin
      idx_d = 2'd0;
    end else if (r_hs && idx_q != 2'd2) begin
      idx_d = idx_q + 2'd1;
    end

    poll_cnt_d = (state_q == S_WAIT) ? poll_cnt_q + 24'd1 : 24'd0;

    tmo_cnt_d = 16'd0;
    if (stall) begin
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
    end

    sweep_err_d = sweep_err_q;
    if (commit_now) begin
      sweep_err_d = 1'b0;
    end else if (r_hs && m_axil_rresp != 2'b00) begin
      sweep_err_d = 1'b1;
    end

    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    busy_d    = (state_d == S_AR) || (state_d == S_R) || (state_d == S_COMMIT);
    // Address only changes on entry to AR, so it is stable for the whole AR phase.
    araddr_d  = (state_d == S_AR) ? BASE_ADDR + {28'd0, idx_d, 2'b00} : araddr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q         <= 2'd0;
      poll_cnt_q    <= 24'd0;
      tmo_cnt_q     <= 16'd0;
      boot_q        <= 1'b1;
      sweep_err_q   <= 1'b0;
      stage0_q      <= 32'd0;
      stage1_q      <= 32'd0;
      araddr_q      <= BASE_ADDR;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      busy_q        <= 1'b0;
      snap0_q       <= 32'd0;
      snap1_q       <= 32'd0;
      snap2_q       <= 32'd0;
      snap_valid_q  <= 1'b0;
      err_slverr_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      poll_cnt_q  <= poll_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sweep_err_q <= sweep_err_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      // Auto-start on enable only applies to the first IDLE after reset.
      if (state_q != S_IDLE) boot_q <= 1'b0;
      if (r_hs && idx_q == 2'd0) stage0_q <= m_axil_rdata;
      if (r_hs && idx_q == 2'd1) stage1_q <= m_axil_rdata;
      if (commit_ok) begin
        snap0_q <= stage0_q;
        snap1_q <= stage1_q;
        snap2_q <= m_axil_rdata;
      end
      snap_valid_q  <= commit_ok;
      // Set has priority over clear.
      err_slverr_q  <= (err_slverr_q & ~clear_err) | (commit_now & commit_err);
      err_timeout_q <= (err_timeout_q & ~clear_err) | tmo_hit;
    end
  end

`ifdef PACKET_ROUTER_POLL_DELTA_EN
  logic [31:0] delta0_q, delta1_q, delta2_q;

  // Unsigned 32-bit subtraction wraps, so a counter rollover still yields the small true delta.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      delta0_q <= 32'd0;
      delta1_q <= 32'd0;
      delta2_q <= 32'd0;
    end else if (commit_ok) begin
      delta0_q <= stage0_q - snap0_q;
      delta1_q <= stage1_q - snap1_q;
      delta2_q <= m_axil_rdata - snap2_q;
    end
  end

  assign delta_out0    = delta0_q;
  assign delta_out1    = delta1_q;
  assign delta_dropped = delta2_q;
`else
  assign delta_out0    = 32'd0;
  assign delta_out1    = 32'd0;
  assign delta_dropped = 32'd0;
`endif

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign snap_out0      = snap0_q;
  assign snap_out1      = snap1_q;
  assign snap_dropped   = snap2_q;
  assign snap_valid     = snap_valid_q;
  assign busy           = busy_q;
  assign err_slverr     = err_slverr_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_packet_router_stats_poller.sv
// tb/tb_packet_router_stats_poller.sv - self-checking bench for packet_router_stats_poller
module tb_packet_router_stats_poller;

  logic        clk;
  logic        resetn;
  logic        start, enable, clear_err;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid, m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid, m_axil_rready;
  logic [31:0] snap_out0, snap_out1, snap_dropped;
  logic [31:0] delta_out0, delta_out1, delta_dropped;
  logic        snap_valid, busy, err_slverr, err_timeout;

  packet_router_stats_poller #(
    .BASE_ADDR(32'h0), .POLL_INTERVAL(5), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .enable(enable), .clear_err(clear_err),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready),
    .snap_out0(snap_out0), .snap_out1(snap_out1), .snap_dropped(snap_dropped),
    .delta_out0(delta_out0), .delta_out1(delta_out1), .delta_dropped(delta_dropped),
    .snap_valid(snap_valid), .busy(busy), .err_slverr(err_slverr), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Slave configuration, written only by the main sequence.
  logic [31:0] mem [4];
  int          ar_stall_req = 0;  // arready held low this many cycles for the read at address 0
  int          err_idx = -1;      // register index answered with err_code, -1 for none
  logic [1:0]  err_code = 2'b10;

  // AXI-Lite slave model: inputs change on the falling edge only.
  initial begin : slave
    int          stalled;
    bit          pend, arhs_p, rhs_p;
    logic [31:0] addr_p, paddr;
    logic [1:0]  sidx;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'd0; m_axil_rresp = 2'b00;
    stalled = 0; pend = 0; arhs_p = 0; rhs_p = 0; addr_p = 32'd0; paddr = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'd0; m_axil_rresp = 2'b00;
        stalled = 0; pend = 0; arhs_p = 0; rhs_p = 0;
      end else begin
        if (rhs_p) pend = 0;
        if (arhs_p) begin pend = 1; paddr = addr_p; end
        m_axil_arready = m_axil_arvalid && !(m_axil_araddr == 32'h0 && stalled < ar_stall_req);
        if (m_axil_arvalid && !m_axil_arready) stalled++;
        sidx = paddr[3:2];
        m_axil_rvalid = pend;
        m_axil_rdata  = pend ? mem[sidx] : 32'd0;
        m_axil_rresp  = (pend && int'(sidx) == err_idx) ? err_code : 2'b00;
        arhs_p = m_axil_arvalid && m_axil_arready;
        if (arhs_p) stalled = 0;
        addr_p = m_axil_araddr;
        rhs_p  = m_axil_rvalid && m_axil_rready;
      end
    end
  end

  // Results of the most recent sweep_once.
  int          sv_cyc, done_cyc, n_ar;
  logic [31:0] ar_log [8];

  // Pulses start (called on a falling edge) and records, per cycle after the pulse,
  // rising arvalid addresses, the snap_valid cycle and the first cycle busy is low.
  task automatic sweep_once(input int budget);
    bit prev_arv;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_ar = 0; sv_cyc = -1; done_cyc = -1; prev_arv = 0;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      if (m_axil_arvalid && !prev_arv) begin
        if (n_ar < 8) ar_log[n_ar] = m_axil_araddr;
        n_ar++;
      end
      prev_arv = m_axil_arvalid;
      if (snap_valid && sv_cyc < 0) sv_cyc = c;
      if (!busy) done_cyc = c;
      if (done_cyc < 0) @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_arvalid"}, m_axil_arvalid, 0);
    chk({tag, "_rready"}, m_axil_rready, 0);
    chk({tag, "_araddr"}, m_axil_araddr, 32'h0);
    chk({tag, "_snap0"}, snap_out0, 0);
    chk({tag, "_snap1"}, snap_out1, 0);
    chk({tag, "_snapd"}, snap_dropped, 0);
    chk({tag, "_deltas"}, {delta_out0 | delta_out1 | delta_dropped}, 0);
    chk({tag, "_flags"}, {snap_valid, busy, err_slverr, err_timeout}, 4'b0000);
  endtask

  typedef struct {
    logic [31:0] d0, d1, d2;
    int          eidx;
    logic [31:0] e0, e1, e2;
    logic [31:0] edelta0;
    bit          evalid;
  } vec_t;

  vec_t tbl [5];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] md [3];
    logic [31:0] ms [3];
    logic [31:0] mdl [3];
    bit          m_slverr, m_valid, stable;
    logic        e256, e257;
    int          sv, svq[$], arq[$], nxt, ar_seen, found;
    bit          prev;

    resetn = 1'b0; start = 1'b0; enable = 1'b0; clear_err = 1'b0;
    for (int k = 0; k < 4; k++) mem[k] = 32'd0;

    tbl[0] = '{32'd10, 32'd20, 32'd3, -1, 32'd10, 32'd20, 32'd3, 32'd10, 1'b1};
    tbl[1] = '{32'hFFFF_FFF0, 32'd5, 32'd7, -1, 32'hFFFF_FFF0, 32'd5, 32'd7, 32'hFFFF_FFE6, 1'b1};
    tbl[2] = '{32'h0000_0010, 32'd6, 32'd8, -1, 32'h0000_0010, 32'd6, 32'd8, 32'h20, 1'b1};
    tbl[3] = '{32'd1, 32'd2, 32'd3, 1, 32'h0000_0010, 32'd6, 32'd8, 32'h20, 1'b0};
    tbl[4] = '{32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, -1, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEDF, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    resetn = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Table-driven single sweeps with zero-wait slave.
    for (int i = 0; i < 5; i++) begin
      mem[0] = tbl[i].d0; mem[1] = tbl[i].d1; mem[2] = tbl[i].d2; err_idx = tbl[i].eidx;
      sweep_once(30);
      chk($sformatf("v%0d_busy_low_cycle", i), done_cyc, 8);
      chk($sformatf("v%0d_snap_valid_cycle", i), sv_cyc, tbl[i].evalid ? 7 : -1);
      chk($sformatf("v%0d_num_ar", i), n_ar, 3);
      chk($sformatf("v%0d_araddr0", i), ar_log[0], 32'h0);
      chk($sformatf("v%0d_araddr1", i), ar_log[1], 32'h4);
      chk($sformatf("v%0d_araddr2", i), ar_log[2], 32'h8);
      chk($sformatf("v%0d_snap0", i), snap_out0, tbl[i].e0);
      chk($sformatf("v%0d_snap1", i), snap_out1, tbl[i].e1);
      chk($sformatf("v%0d_snapd", i), snap_dropped, tbl[i].e2);
      chk($sformatf("v%0d_slverr", i), err_slverr, !tbl[i].evalid);
`ifdef PACKET_ROUTER_POLL_DELTA_EN
      chk($sformatf("v%0d_delta0", i), delta_out0, tbl[i].edelta0);
`else
      chk($sformatf("v%0d_delta0", i), delta_out0, 32'd0);
`endif
      if (!tbl[i].evalid) begin
        clear_err = 1'b1; @(negedge clk); clear_err = 1'b0; @(negedge clk);
        chk($sformatf("v%0d_slverr_cleared", i), err_slverr, 0);
      end
    end
    err_idx = -1;

    // Timeout: arready withheld 300 cycles on the first read.
    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003;
    ar_stall_req = 300;
    start = 1'b1; @(negedge clk); start = 1'b0;
    stable = 1; sv = -1; e256 = 1'bx; e257 = 1'bx;
    for (int c = 1; c <= 330; c++) begin
      if (c <= 300 && !(m_axil_arvalid && m_axil_araddr == 32'h0)) stable = 0;
      if (c == 256) e256 = err_timeout;
      if (c == 257) e257 = err_timeout;
      if (snap_valid && sv < 0) sv = c;
      @(negedge clk);
    end
    chk("tmo_ar_stable", stable, 1);
    chk("tmo_flag_before", e256, 0);
    chk("tmo_flag_after", e257, 1);
    chk("tmo_snap_valid_cycle", sv, 307);
    chk("tmo_snap0", snap_out0, 32'hAAAA_0001);
    chk("tmo_snapd", snap_dropped, 32'hCCCC_0003);
    chk("tmo_no_slverr", err_slverr, 0);
    ar_stall_req = 0;
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0; @(negedge clk);
    chk("tmo_cleared", err_timeout, 0);

    // Periodic polling with POLL_INTERVAL=5, then enable dropped during WAIT.
    enable = 1'b1; start = 1'b1; @(negedge clk); start = 1'b0;
    prev = 0;
    for (int c = 1; c <= 34; c++) begin
      if (snap_valid) svq.push_back(c);
      if (m_axil_arvalid && !prev) arq.push_back(c);
      prev = m_axil_arvalid;
      if (c < 34) @(negedge clk);
    end
    chk("per_commit_count", svq.size(), 3);
    foreach (svq[k]) begin
      if (svq[k] + 6 <= 34) begin
        nxt = -1;
        foreach (arq[j]) if (nxt < 0 && arq[j] > svq[k]) nxt = arq[j];
        chk($sformatf("per_restart_gap%0d", k), nxt - svq[k], 6);
      end
    end
    enable = 1'b0;
    ar_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_axil_arvalid) ar_seen++;
    end
    chk("per_stop_no_arvalid", ar_seen, 0);
    chk("per_stop_not_busy", busy, 0);

    // Reset asserted while in R.
    start = 1'b1; @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (m_axil_rready) found = 1;
      else @(negedge clk);
    end
    chk("rst_reached_r", found, 1);
    resetn = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mem[0] = 32'h0000_0111; mem[1] = 32'h0000_0222; mem[2] = 32'h0000_0333;
    sweep_once(30);
    chk("rst_clean_snap_valid_cycle", sv_cyc, 7);
    chk("rst_clean_snap0", snap_out0, 32'h111);
    chk("rst_clean_snap1", snap_out1, 32'h222);
    chk("rst_clean_snapd", snap_dropped, 32'h333);
`ifdef PACKET_ROUTER_POLL_DELTA_EN
    chk("rst_clean_delta0", delta_out0, 32'h111);
`else
    chk("rst_clean_delta0", delta_out0, 32'd0);
`endif

    // Randomized sweeps against a snapshot-level reference model.
    ms[0] = 32'h111; ms[1] = 32'h222; ms[2] = 32'h333;
    mdl[0] = 32'h111; mdl[1] = 32'h222; mdl[2] = 32'h333;
    m_slverr = 0;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 3; k++) begin md[k] = $urandom(); mem[k] = md[k]; end
      err_idx      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      err_code     = 2'($urandom_range(1, 3));
      ar_stall_req = int'($urandom_range(0, 3));
      sweep_once(60);
      m_valid = (err_idx < 0);
      if (m_valid) begin
        for (int k = 0; k < 3; k++) begin mdl[k] = md[k] - ms[k]; ms[k] = md[k]; end
      end else begin
        m_slverr = 1;
      end
      chk($sformatf("rnd%0d_done", i), done_cyc > 0, 1);
      chk($sformatf("rnd%0d_snap_valid", i), sv_cyc > 0, m_valid);
      chk($sformatf("rnd%0d_snap0", i), snap_out0, ms[0]);
      chk($sformatf("rnd%0d_snap1", i), snap_out1, ms[1]);
      chk($sformatf("rnd%0d_snapd", i), snap_dropped, ms[2]);
`ifdef PACKET_ROUTER_POLL_DELTA_EN
      chk($sformatf("rnd%0d_delta0", i), delta_out0, mdl[0]);
      chk($sformatf("rnd%0d_delta1", i), delta_out1, mdl[1]);
      chk($sformatf("rnd%0d_deltad", i), delta_dropped, mdl[2]);
`else
      chk($sformatf("rnd%0d_deltas", i), {delta_out0, delta_out1, delta_dropped}, 96'd0);
`endif
      chk($sformatf("rnd%0d_slverr", i), err_slverr, m_slverr);
      if ($urandom_range(0, 2) == 0) begin
        clear_err = 1'b1; @(negedge clk); clear_err = 1'b0; @(negedge clk);
        m_slverr = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
